// File: rtl/shift_seq_if.sv
// Start/busy/done handshake and operand/result bus of the multi-cycle shift sequencer.
interface shift_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [1:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] data_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, shamt, data_in, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, shamt, data_in, flush,
    output busy, done, result
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer: shift-by-2 per cycle plus one shift-by-1 for an odd amount.
// Define SHIFT_ROTATE_EN to make op=11 a rotate-right; otherwise op=11 behaves as SLL.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  shift_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  // One step of the iterated shifter; by2 selects a 2-bit step, else a 1-bit step.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] a,
                                                  input logic [1:0] o,
                                                  input logic by2);
    logic [WIDTH-1:0] r;
    r = a;
    case (o)
      2'b01:   r = by2 ? {2'b00, a[WIDTH-1:2]} : {1'b0, a[WIDTH-1:1]};
      2'b10:   r = by2 ? {{2{a[WIDTH-1]}}, a[WIDTH-1:2]} : {a[WIDTH-1], a[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      2'b11:   r = by2 ? {a[1:0], a[WIDTH-1:2]} : {a[0], a[WIDTH-1:1]};
`endif
      default: r = by2 ? {a[WIDTH-3:0], 2'b00} : {a[WIDTH-2:0], 1'b0};
    endcase
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update; flush overrides everything but reset.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            acc_d   = bus.data_in;
            rem_d   = bus.shamt;
            op_d    = bus.op;
            state_d = (bus.shamt != {SHW{1'b0}}) ? ST_SHIFT : ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (rem_q >= SHW'(2)) begin
            acc_d   = shift_step(acc_q, op_q, 1'b1);
            rem_d   = rem_q - SHW'(2);
            state_d = (rem_q == SHW'(2)) ? ST_DONE : ST_SHIFT;
          end else if (rem_q == SHW'(1)) begin
            acc_d   = shift_step(acc_q, op_q, 1'b0);
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          result_d = acc_q;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // The finished value bypasses result_q during the done cycle so it is valid alongside done.
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE) && !bus.flush;
  assign bus.result = bus.done ? acc_q : result_q;

endmodule
